if_fetch_stage: RTL and testbench

- IF stage of the 5-stage MIPS pipeline; producer end of the IF→ID link and consumer of ID's branch-redirect bus.
- Owns the PC register and drives the instruction SRAM read port.
- Publishes {ce, pc} to ID; ID receives the instruction one cycle later on inst_sram_rdata.
- Applies ID's branch/jump redirects. A redirect that arrives while IF is stalled is buffered until the stall releases.

---
 rtl/if_fetch_stage_pkg.sv | 22 ++
 rtl/if_fetch_stage_redirect_buf.sv | 26 ++
 rtl/if_fetch_stage.sv | 124 ++++++++++++
 tb/tb_if_fetch_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the IF stage: stall bus, bus widths, reset PC and
// fetch FSM state encoding.
package if_fetch_stage_pkg;

  localparam int unsigned STALL_WD    = 6;
  localparam int unsigned IF_TO_ID_WD = 33;
  localparam int unsigned BR_WD       = 33;

  typedef logic [STALL_WD-1:0] StallBus;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_redirect_buf.sv
// Holds a branch redirect that arrived while IF was stalled, until the stall
// releases and the PC consumes it.
module if_redirect_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        consume,
  input  logic [31:0] br_addr,
  output logic        pend_v,
  output logic [31:0] pend_addr
);

  // capture outranks consume; a later redirect overwrites an earlier one
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v    <= 1'b0;
      pend_addr <= '0;
    end else if (capture) begin
      pend_v    <= 1'b1;
      pend_addr <= br_addr;
    end else if (consume) begin
      pend_v    <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: PC register, boot/run/hold FSM and instruction SRAM read drive.
// Optional macro IF_PERF_CNT_EN adds perf_fetch_cnt / perf_redir_cnt outputs.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetch_cnt,
  output logic [31:0]            perf_redir_cnt
`endif
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc_reg, pc_nxt, next_pc;
  logic         ce_reg, ce_nxt;
  logic         br_e;
  logic [31:0]  br_addr;
  logic         stop;
  logic         pend_v;
  logic [31:0]  pend_addr;
  logic         capture, consume;
  logic         stall_unused;

  assign {br_e, br_addr} = br_bus;
  assign stop            = (stall[0] == Stop);
  assign stall_unused    = ^stall[5:1];

  if_redirect_buf u_redirect_buf (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .consume   (consume),
    .br_addr   (br_addr),
    .pend_v    (pend_v),
    .pend_addr (pend_addr)
  );

  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (br_e)        next_pc = br_addr;
    else if (pend_v) next_pc = pend_addr;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_reg;
    ce_nxt    = ce_reg;
    capture   = 1'b0;
    consume   = 1'b0;
    unique case (state)
      S_BOOT: begin
        if (!stop) begin
          state_nxt = S_RUN;
          ce_nxt    = 1'b1;
          pc_nxt    = RESET_PC + 32'd4;
        end
      end
      S_RUN: begin
        if (!stop) begin
          pc_nxt  = next_pc;
          ce_nxt  = 1'b1;
          consume = 1'b1;
        end else if (br_e) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!stop) begin
          pc_nxt    = next_pc;
          consume   = 1'b1;
          state_nxt = S_RUN;
        end else if (br_e) begin
          capture = 1'b1;
        end
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_BOOT;
      pc_reg <= RESET_PC;
      ce_reg <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc_reg <= pc_nxt;
      ce_reg <= ce_nxt;
    end
  end

  assign if_to_id_bus    = {ce_reg, pc_reg};
  assign inst_sram_en    = ce_reg;
  assign inst_sram_wen   = '0;
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wdata = '0;

`ifdef IF_PERF_CNT_EN
  logic redir_apply;
  // a redirect counts only when it actually lands in pc_reg (never in BOOT)
  assign redir_apply = (state != S_BOOT) && !stop && (br_e || pend_v);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_redir_cnt <= '0;
    end else begin
      if (ce_reg && !stop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redir_apply)     perf_redir_cnt <= perf_redir_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed pins plus random stimulus
// against a behavioural fetch model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_redir_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_redir_cnt  (perf_redir_cnt)
`endif
  );

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 0;

  // behavioural model: current fetch address, whether fetching has started,
  // and an optional remembered redirect
  logic [31:0] m_pc;
  logic        m_ce;
  bit          m_booted;
  bit          m_have_pend;
  logic [31:0] m_pend;
  logic [31:0] m_fetch, m_redir;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic be, input logic [31:0] ba);
    if (r) begin
      m_pc = 32'hBFBF_FFFC; m_ce = 1'b0; m_booted = 0; m_have_pend = 0;
      m_pend = '0; m_fetch = '0; m_redir = '0;
    end else if (!m_booted) begin
      if (!s) begin
        m_booted = 1; m_ce = 1'b1; m_pc = 32'hBFC0_0000;
      end
    end else if (!s) begin
      m_fetch = m_fetch + 1;
      if (be) begin
        m_pc = ba; m_redir = m_redir + 1;
      end else if (m_have_pend) begin
        m_pc = m_pend; m_redir = m_redir + 1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_have_pend = 0;
    end else if (be) begin
      m_have_pend = 1; m_pend = ba;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic be, input logic [31:0] ba);
    @(negedge clk);
    #1;
    rst    = r;
    stall  = {5'($urandom), s};
    br_bus = {be, ba};
    model_step(r, s, be, ba);
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input logic ce, input logic [31:0] addr);
    chk({name, "_model_addr"}, {32'd0, m_pc}, {32'd0, addr});
    chk({name, "_model_ce"}, {63'd0, m_ce}, {63'd0, ce});
    chk({name, "_addr"}, {32'd0, inst_sram_addr}, {32'd0, addr});
    chk({name, "_ce"}, {63'd0, inst_sram_en}, {63'd0, ce});
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("addr", {32'd0, inst_sram_addr}, {32'd0, m_pc});
      chk("en", {63'd0, inst_sram_en}, {63'd0, m_ce});
      chk("if_to_id_bus", {31'd0, if_to_id_bus}, {31'd0, m_ce, m_pc});
      chk("wen", {60'd0, inst_sram_wen}, 64'd0);
      chk("wdata", {32'd0, inst_sram_wdata}, 64'd0);
`ifdef IF_PERF_CNT_EN
      chk("perf_fetch", {32'd0, perf_fetch_cnt}, {32'd0, m_fetch});
      chk("perf_redir", {32'd0, perf_redir_cnt}, {32'd0, m_redir});
`endif
    end
  end

  initial begin
    logic        r, s, be;
    logic [31:0] ba;
    rst = 1'b1; stall = '0; br_bus = '0;

    step(1, 0, 0, 0);
    check_en = 1;
    step(1, 0, 0, 0);
    pin("reset", 1'b0, 32'hBFBF_FFFC);
    chk("reset_wen", {60'd0, inst_sram_wen}, 64'd0);

    step(0, 1, 0, 0);                pin("boot_stall", 1'b0, 32'hBFBF_FFFC);
    step(0, 0, 0, 0);                pin("first_fetch", 1'b1, 32'hBFC0_0000);
    step(0, 0, 0, 0);                pin("seq1", 1'b1, 32'hBFC0_0004);
    step(0, 0, 0, 0);                pin("seq2", 1'b1, 32'hBFC0_0008);
    step(0, 0, 0, 0);                pin("seq3", 1'b1, 32'hBFC0_000C);
    step(0, 0, 0, 0);                pin("seq4", 1'b1, 32'hBFC0_0010);
    step(0, 0, 1, 32'hBFC0_0100);    pin("branch", 1'b1, 32'hBFC0_0100);
    step(0, 0, 0, 0);                pin("after_branch", 1'b1, 32'hBFC0_0104);
    step(0, 0, 1, 32'hBFC0_0020);    pin("to_20", 1'b1, 32'hBFC0_0020);

    step(0, 1, 1, 32'hBFC0_0200);    pin("stall1", 1'b1, 32'hBFC0_0020);
    step(0, 1, 0, 0);                pin("stall2", 1'b1, 32'hBFC0_0020);
    step(0, 1, 0, 0);                pin("stall3", 1'b1, 32'hBFC0_0020);
    step(0, 0, 0, 0);                pin("pend_applied", 1'b1, 32'hBFC0_0200);
    step(0, 0, 0, 0);                pin("pend_cleared", 1'b1, 32'hBFC0_0204);

    step(0, 1, 1, 32'hBFC0_0300);    pin("hold_a", 1'b1, 32'hBFC0_0204);
    step(0, 1, 1, 32'hBFC0_0400);    pin("hold_b", 1'b1, 32'hBFC0_0204);
    step(0, 0, 0, 0);                pin("last_wins", 1'b1, 32'hBFC0_0400);
    step(0, 0, 0, 0);                pin("after_last", 1'b1, 32'hBFC0_0404);

    step(0, 1, 1, 32'hBFC0_0600);    pin("hold_c", 1'b1, 32'hBFC0_0404);
    step(0, 0, 1, 32'hBFC0_0700);    pin("live_beats_pend", 1'b1, 32'hBFC0_0700);
    step(0, 0, 0, 0);                pin("after_live", 1'b1, 32'hBFC0_0704);

    step(0, 1, 1, 32'hBFC0_0500);    pin("hold_d", 1'b1, 32'hBFC0_0704);
    step(1, 0, 0, 0);                pin("mid_reset", 1'b0, 32'hBFBF_FFFC);
    step(0, 0, 0, 0);                pin("restart", 1'b1, 32'hBFC0_0000);
    step(0, 0, 0, 0);                pin("pend_discarded", 1'b1, 32'hBFC0_0004);

    step(0, 0, 1, 32'hFFFF_FFFC);    pin("near_top", 1'b1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);                pin("wrap", 1'b1, 32'h0000_0000);
    step(0, 0, 1, 32'h0000_1003);    pin("misaligned", 1'b1, 32'h0000_1003);
    step(0, 0, 0, 0);                pin("misaligned_inc", 1'b1, 32'h0000_1007);

    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      s  = ($urandom_range(0, 2) == 0);
      be = m_ce && !r && ($urandom_range(0, 3) == 0);
      ba = $urandom;
      if ($urandom_range(0, 3) != 0) ba[1:0] = 2'b00;
      step(r, s, be, ba);
    end

`ifdef IF_PERF_CNT_EN
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int k = 0; k < 10; k++)
      step(0, 0, (k == 3 || k == 7), 32'hBFC0_1000 + 32'(k) * 32'h100);
    chk("perf_fetch_10", {32'd0, perf_fetch_cnt}, 64'd10);
    chk("perf_redir_2", {32'd0, perf_redir_cnt}, 64'd2);
    chk("model_fetch_10", {32'd0, m_fetch}, 64'd10);
    chk("model_redir_2", {32'd0, m_redir}, 64'd2);
`endif

    @(negedge clk);
    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
